// File: rtl/bus_decoder.sv
// Address decoder for the picorv32 native bus: routes one request to the lowest matching slave and reports unmapped/timeout errors.
// Hit completes when the slave is ready (1 cycle minimum), unmapped in 2 cycles, timeout after TIMEOUT_CYCLES; master waits on m_ready, a DONE cycle separates transfers.
module bus_decoder #(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFF00_0000}},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m_valid,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  output logic                       err_pulse,
  output logic [31:0]                err_addr,
  output logic [7:0]                 err_count
);

  localparam int          SW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR, DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   hit_idx;
  logic            hit;
  logic [15:0]     cnt;
  logic            sel_ready;
  logic [31:0]     sel_rdata;
  logic            timeout_hit;
  logic            err_cpl;

  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[32*i +: 32]) == (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign sel_ready   = s_ready[sel];
  assign sel_rdata   = s_rdata[32*sel +: 32];
  assign timeout_hit = (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ERROR spends one silent cycle (cnt == 0) before completing, mirroring the decode slot of a hit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (m_valid) state_nxt = hit ? ACTIVE : ERROR;
      ACTIVE: begin
        if (!m_valid)                      state_nxt = IDLE;
        else if (sel_ready || timeout_hit) state_nxt = DONE;
      end
      ERROR:  if (cnt != 16'd0) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ready = 1'b0;
    m_rdata = 32'h0;
    s_valid = '0;
    err_cpl = 1'b0;
    if (!reset) begin
      case (state)
        ACTIVE: begin
          if (m_valid) begin
            if (sel_ready) begin
              m_ready      = 1'b1;
              m_rdata      = sel_rdata;
              s_valid[sel] = 1'b1;
            end else if (timeout_hit) begin
              m_ready = 1'b1;
              m_rdata = ERR_RDATA;
              err_cpl = 1'b1;
            end else begin
              s_valid[sel] = 1'b1;
            end
          end
        end
        ERROR: begin
          if (cnt != 16'd0) begin
            m_ready = 1'b1;
            m_rdata = ERR_RDATA;
            err_cpl = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_pulse = err_cpl;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= '0;
      cnt       <= '0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      if (state == IDLE) sel <= hit_idx;
      if ((state == ACTIVE || state == ERROR) && state_nxt == state) cnt <= cnt + 16'd1;
      else                                                          cnt <= '0;
      if (err_cpl) begin
        err_addr <= m_addr;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: driver pushes expected completions, a negedge monitor pops and compares.
module tb_bus_decoder;

  localparam logic [31:0] S0 = 32'h1111_0000;
  localparam logic [31:0] S1 = 32'h2222_0001;
  localparam logic [31:0] S2 = 32'h3333_0002;
  localparam logic [31:0] S3 = 32'h4444_0003;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         m_valid;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err_pulse;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  assign s_rdata = {S3, S2, S1, S0};

  // Slaves 0 and 1 overlap on 0x10xx_xxxx; slave 1 alone covers the rest of 0x1xxx_xxxx.
  bus_decoder #(
    .NUM_SLAVES    (4),
    .SLAVE_BASE    ({32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000}),
    .SLAVE_MASK    ({32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFF00_0000}),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA     (ERRD)
  ) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_pulse(err_pulse), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_eaddr = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_m_ready: got rdata %h with no completion expected", m_rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mon_rdata", 64'(m_rdata), 64'(e.rdata));
          check("mon_err_pulse", 64'(err_pulse), 64'(e.err));
        end
      end else begin
        check("mon_idle_outputs", {31'h0, err_pulse, m_rdata}, 64'h0);
      end
    end
  end

  task automatic access(input logic [31:0] addr, input logic [3:0] wstrb, input int slave,
                        input int rdy_after, input bit others_rdy, input logic [31:0] exp_rdata,
                        input bit exp_err, input int exp_lat, input int exp_svcnt,
                        input logic [3:0] exp_sv, input string name);
    int lat, svcnt, badsv;
    bit done;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    m_valid = 1'b1;
    m_addr  = addr;
    m_wdata = addr ^ 32'h5A5A_5A5A;
    m_wstrb = wstrb;
    lat = 0; svcnt = 0; badsv = 0; done = 1'b0;
    while (!done && lat < 64) begin
      s_ready = others_rdy ? 4'hF : 4'h0;
      s_ready[slave] = (rdy_after >= 0 && svcnt >= rdy_after);
      @(negedge clk);
      if (lat == 0) begin
        check({name, "_passthru"}, {s_wdata, s_addr}, {addr ^ 32'h5A5A_5A5A, addr});
        check({name, "_wstrb"}, 64'(s_wstrb), 64'(wstrb));
      end
      if (m_ready) done = 1'b1;
      else if (s_valid != 4'h0) begin
        if (s_valid == exp_sv) svcnt++;
        else                   badsv++;
      end
      if (!done) begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_wait: no m_ready within 64 cycles", name);
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_svalid_cycles"}, 64'(svcnt), 64'(exp_svcnt));
    check({name, "_svalid_other"}, 64'(badsv), 64'd0);
    if (exp_err) begin
      exp_eaddr = addr;
      if (exp_cnt < 255) exp_cnt++;
    end
    // Hold m_valid through DONE: it must be ignored there.
    @(posedge clk); #1;
    s_ready = 4'h0;
    @(negedge clk);
    check({name, "_done_gap"}, {59'h0, m_ready, s_valid}, 64'h0);
    check({name, "_err_count"}, 64'(err_count), 64'(exp_cnt));
    check({name, "_err_addr"}, 64'(err_addr), 64'(exp_eaddr));
    @(posedge clk); #1;
    m_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0; s_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    m_valid = 1'b1;
    s_ready = 4'hF;
    @(negedge clk);
    check("reset_outputs", {27'h0, err_pulse, m_ready, s_valid, m_rdata}, 64'h0);
    check("reset_err_regs", {24'h0, err_count, err_addr}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0; m_valid = 1'b0; s_ready = 4'h0;
    @(posedge clk); #1;

    access(32'h2000_0010, 4'h0, 2, 3, 1'b1, S2, 1'b0, 4, 3, 4'b0100, "read_slave2");
    access(32'h4000_0100, 4'hF, 3, 0, 1'b0, S3, 1'b0, 1, 0, 4'b1000, "write_slave3_fast");
    access(32'h8000_0000, 4'h0, 0, 0, 1'b1, ERRD, 1'b1, 2, 0, 4'b0000, "unmapped");
    access(32'h1800_0000, 4'h0, 1, -1, 1'b0, ERRD, 1'b1, 8, 7, 4'b0010, "timeout_slave1");
    access(32'h1800_0004, 4'h3, 1, 7, 1'b0, S1, 1'b0, 8, 7, 4'b0010, "ready_at_timeout");
    access(32'h1000_0040, 4'h0, 0, 1, 1'b1, S0, 1'b0, 2, 1, 4'b0001, "overlap_slave0");

    // Master abort mid-ACTIVE: no completion, no error, back to IDLE.
    m_valid = 1'b1; m_addr = 32'h2000_0020; m_wstrb = 4'h0; s_ready = 4'h0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_active_svalid", 64'(s_valid), 64'h4);
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(negedge clk);
    check("abort_outputs", {59'h0, m_ready, s_valid}, 64'h0);
    @(posedge clk); #1;
    check("abort_err_count", 64'(err_count), 64'(exp_cnt));
    access(32'h4000_0000, 4'h0, 3, 0, 1'b0, S3, 1'b0, 1, 0, 4'b1000, "after_abort");

    for (int i = 0; i < 300; i++)
      access(32'h9000_0000 | 32'(i), 4'h0, 0, -1, 1'b0, ERRD, 1'b1, 2, 0, 4'b0000, "unmapped_loop");
    check("err_count_saturated", 64'(err_count), 64'd255);

    // Reset in the middle of an ACTIVE transfer.
    m_valid = 1'b1; m_addr = 32'h2000_0000; s_ready = 4'h0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_active_outputs", {59'h0, m_ready, s_valid}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0; m_valid = 1'b0;
    exp_cnt = 0; exp_eaddr = 32'h0;
    @(negedge clk);
    check("reset_mid_active_err", {24'h0, err_count, err_addr}, 64'h0);
    @(posedge clk); #1;
    access(32'h2000_0004, 4'h0, 2, 0, 1'b0, S2, 1'b0, 1, 0, 4'b0100, "after_reset");

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4: number of slave regions, 1..16.
REQ-002 SHALL have parameter SLAVE_BASE, default {32'h4000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}: packed NUM_SLAVES*32 base addresses, slave i at bits [32*i+31:32*i].
REQ-003 SHALL have parameter SLAVE_MASK, default four copies of 32'hFF00_0000: packed per-slave compare masks.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum wait cycles for slave ready, 1..65535.
REQ-005 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on error.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port m_valid, input, 1: master request valid (picorv32 native bus).
REQ-009 SHALL have port m_addr, input, 32: request address.
REQ-010 SHALL have port m_wdata, input, 32, and port m_wstrb, input, 4: write data and byte strobes; wstrb 0 means read.
REQ-011 SHALL have port m_ready, output, 1: transfer complete.
REQ-012 SHALL have port m_rdata, output, 32: read data to master.
REQ-013 SHALL have port s_valid, output, NUM_SLAVES: one-hot per-slave request.
REQ-014 SHALL have port s_addr, output, 32, s_wdata, output, 32, and s_wstrb, output, 4: direct pass-through of m_addr, m_wdata, m_wstrb.
REQ-015 SHALL have port s_ready, input, NUM_SLAVES: per-slave ready.
REQ-016 SHALL have port s_rdata, input, NUM_SLAVES*32: packed per-slave read data.
REQ-017 SHALL have port err_pulse, output, 1: one-cycle strobe per error completion.
REQ-018 SHALL have port err_addr, output, 32: address of the most recent error.
REQ-019 SHALL have port err_count, output, 8: saturating error count.

Function
REQ-020 SHALL implement FSM states IDLE, ACTIVE, ERROR, DONE.
REQ-021 Decode: slave i matches when (m_addr & MASK_i) == (BASE_i & MASK_i); lowest matching index wins.
REQ-022 IDLE with m_valid and a match: register the index, go to ACTIVE; m_ready is 0 in IDLE.
REQ-023 IDLE with m_valid and no match: go to ERROR.
REQ-024 ACTIVE: s_valid[sel] = m_valid and all other s_valid bits = 0; the timeout counter increments each cycle from 0.
REQ-025 ACTIVE with s_ready[sel]=1: m_ready=1 in the same cycle, m_rdata = s_rdata slice sel, go to DONE.
REQ-026 ACTIVE with counter == TIMEOUT_CYCLES-1 and s_ready[sel]=0: timeout completion: m_ready=1, m_rdata=ERR_RDATA, s_valid=0, go to DONE; error accounting per REQ-030.
REQ-027 Same-cycle s_ready[sel] and timeout: ready wins and no error is recorded.
REQ-028 ERROR: for exactly one cycle, m_ready=1, m_rdata=ERR_RDATA, all s_valid=0; then go to DONE; error accounting per REQ-030.
REQ-029 DONE: lasts one cycle; s_valid=0 and m_ready=0; m_valid is ignored; then go to IDLE, giving back-to-back requests a 1-cycle gap.
REQ-030 Error accounting: err_pulse=1 for the completion cycle; err_addr latches m_addr; err_count increments and saturates at 255.
REQ-031 ACTIVE with m_valid dropped (master abort): s_valid=0, no m_ready, no error, return to IDLE next cycle.
REQ-032 Latency: hit with an immediate-ready slave gives m_ready 1 cycle after m_valid rises; unmapped address gives m_ready 2 cycles after; timeout gives m_ready TIMEOUT_CYCLES cycles after ACTIVE entry.
REQ-033 s_ready bits of unselected slaves SHALL be ignored.
REQ-034 m_rdata SHALL be 32'h0 whenever m_ready=0.

Reset
REQ-035 With reset=1 at a clock edge: state=IDLE, counter=0, err_count=0, err_addr=0, err_pulse=0; m_ready=0 and s_valid=0 combinationally while reset is high.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer without m_ready and without error accounting.

Verification
REQ-037 Read 0x2000_0010, slave 2 ready 3 cycles after s_valid -> s_valid=4'b0100 for 3 cycles; m_ready with slave-2 rdata; err_count stays 0.
REQ-038 Access 0x8000_0000 (unmapped) -> m_ready 2 cycles later, m_rdata=0xDEADBEEF, err_pulse for 1 cycle, err_addr=0x8000_0000, err_count=1.
REQ-039 TIMEOUT_CYCLES=8, slave 1 never ready -> s_valid[1] high 7 cycles, m_ready at cycle 8 with 0xDEADBEEF, err_pulse=1.
REQ-040 Overlapping slaves 0 and 1 on one address -> only s_valid[0] asserted.
REQ-041 300 unmapped accesses -> err_count saturates at 255; then reset mid-ACTIVE -> IDLE, err_count=0, no m_ready.
